counter_mod_updn: RTL and testbench

- Parametrised successor to the team's fixed 9-bit enable/clear counter.
- Adds generic width, arbitrary modulus, up/down direction, parallel load, a wrap-or-saturate mode, an enable prescaler, and terminal-count/overflow flags.
- Used as the general event/timebase counter in lab designs, fed by the shared clk generator module.

---
 rtl/counter_mod_updn_if.sv | 28 ++
 rtl/counter_mod_updn.sv | 77 +++++++
 tb/tb_counter_mod_updn.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/counter_mod_updn_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_mod_updn_if : control/status bundle for counter_mod_updn   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface counter_mod_updn_if #(
  parameter int WIDTH = 9
);
  logic             enable;
  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output enable, sclr, load, load_val, up_dn,
    input  count, tc, ovf
  );

  modport slave (
    input  enable, sclr, load, load_val, up_dn,
    output count, tc, ovf
  );
endinterface
`default_nettype wire

// File: rtl/counter_mod_updn.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_mod_updn : modulo up/down counter, prescaler, wrap/saturate |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter_mod_updn #(
  parameter int              WIDTH    = 9,
  parameter longint unsigned MODULUS  = 512,
  parameter int              SATURATE = 0,
  parameter int              PRESCALE = 1
) (
  input  wire logic         clk,
  input  wire logic         clr_n,
  counter_mod_updn_if.slave bus
);

  localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MODULUS - 1);
  localparam logic [15:0]      C_PRE_MAX = 16'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [15:0]      pre_q, pre_d;
  logic             ovf_q, ovf_d;
  logic             w_tick;

  assign w_tick = bus.enable && (pre_q == C_PRE_MAX);

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    ovf_d   = 1'b0;
    if (bus.sclr) begin
      count_d = '0;
      pre_d   = '0;
    end else if (bus.load) begin
      // Out-of-range loads clamp so count never leaves 0..MODULUS-1
      count_d = (bus.load_val > C_MAX) ? C_MAX : bus.load_val;
      pre_d   = '0;
    end else if (bus.enable) begin
      pre_d = w_tick ? 16'd0 : pre_q + 16'd1;
      if (w_tick) begin
        if (bus.up_dn) begin
          if (count_q == C_MAX) begin
            ovf_d = 1'b1;
            if (SATURATE == 0) count_d = '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            ovf_d = 1'b1;
            if (SATURATE == 0) count_d = C_MAX;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
      pre_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.tc    = bus.up_dn ? (count_q == C_MAX) : (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_updn.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_counter_mod_updn : three configurations against a queue model   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_counter_mod_updn;

  logic clk   = 1'b0;
  logic clr_n = 1'b1;
  always #10 clk = ~clk;

  counter_mod_updn_if #(.WIDTH(9)) if0 ();
  counter_mod_updn_if #(.WIDTH(4)) if1 ();
  counter_mod_updn_if #(.WIDTH(4)) if2 ();

  counter_mod_updn #(.WIDTH(9), .MODULUS(512), .SATURATE(0), .PRESCALE(1))
    u_dut0 (.clk(clk), .clr_n(clr_n), .bus(if0.slave));
  counter_mod_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(3))
    u_dut1 (.clk(clk), .clr_n(clr_n), .bus(if1.slave));
  counter_mod_updn #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1))
    u_dut2 (.clk(clk), .clr_n(clr_n), .bus(if2.slave));

  int c_mod [3] = '{512, 10, 10};
  int c_sat [3] = '{0, 0, 1};
  int c_pre [3] = '{1, 3, 1};
  int c_wid [3] = '{9, 4, 4};

  int m_cnt [3] = '{0, 0, 0};
  int m_en  [3] = '{0, 0, 0};

  typedef struct {
    int inst;
    int cnt;
    bit ovf;
    bit tc;
  } exp_t;
  exp_t sbq [$];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(string nm, int act, int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
  endfunction

  // Model: enabled cycles are counted; every PRESCALE-th one moves count by +/-1
  function automatic void model(int i, bit en, bit sc, bit ld, int lv, bit up);
    int lvi = lv % (1 << c_wid[i]);
    bit ov  = 1'b0;
    int nxt;
    if (!clr_n) begin
      m_cnt[i] = 0;
      m_en[i]  = 0;
    end else if (sc) begin
      m_cnt[i] = 0;
      m_en[i]  = 0;
    end else if (ld) begin
      m_cnt[i] = (lvi < c_mod[i]) ? lvi : c_mod[i] - 1;
      m_en[i]  = 0;
    end else if (en) begin
      m_en[i]++;
      if (m_en[i] == c_pre[i]) begin
        m_en[i] = 0;
        nxt = m_cnt[i] + (up ? 1 : -1);
        if (nxt < 0 || nxt >= c_mod[i]) begin
          ov = 1'b1;
          if (c_sat[i] == 0) m_cnt[i] = (nxt + c_mod[i]) % c_mod[i];
        end else begin
          m_cnt[i] = nxt;
        end
      end
    end
    sbq.push_back('{i, m_cnt[i], ov,
                    up ? (m_cnt[i] == c_mod[i] - 1) : (m_cnt[i] == 0)});
  endfunction

  task automatic drive(bit en, bit sc, bit ld, int lv, bit up);
    if0.enable = en;  if1.enable = en;  if2.enable = en;
    if0.sclr   = sc;  if1.sclr   = sc;  if2.sclr   = sc;
    if0.load   = ld;  if1.load   = ld;  if2.load   = ld;
    if0.up_dn  = up;  if1.up_dn  = up;  if2.up_dn  = up;
    if0.load_val = 9'(lv);
    if1.load_val = 4'(lv);
    if2.load_val = 4'(lv);
  endtask

  task automatic cyc(bit rn, bit en, bit sc, bit ld, int lv, bit up);
    @(negedge clk);
    clr_n = rn;
    drive(en, sc, ld, lv, up);
    for (int i = 0; i < 3; i++) model(i, en, sc, ld, lv, up);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_count0"}, int'(if0.count), 0);
    check({tag, "_count1"}, int'(if1.count), 0);
    check({tag, "_count2"}, int'(if2.count), 0);
    check({tag, "_ovf0"}, int'(if0.ovf), 0);
    check({tag, "_ovf1"}, int'(if1.ovf), 0);
    check({tag, "_ovf2"}, int'(if2.ovf), 0);
  endtask

  // Short asynchronous reset pulse entirely between two rising edges
  task automatic reset_pulse();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 0, 1'b1);
    #2 clr_n = 1'b0;
    #1 check_zero("async_rst");
    check("async_rst_tc0", int'(if0.tc), 0);
    #4 clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_en[i]  = 0;
      model(i, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    end
  endtask

  exp_t mon_e;
  int   mon_c;
  int   mon_o;
  int   mon_t;
  always @(posedge clk) begin
    #1;
    while (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      case (mon_e.inst)
        0:       begin mon_c = int'(if0.count); mon_o = int'(if0.ovf); mon_t = int'(if0.tc); end
        1:       begin mon_c = int'(if1.count); mon_o = int'(if1.ovf); mon_t = int'(if1.tc); end
        default: begin mon_c = int'(if2.count); mon_o = int'(if2.ovf); mon_t = int'(if2.tc); end
      endcase
      check($sformatf("count[%0d]", mon_e.inst), mon_c, mon_e.cnt);
      check($sformatf("ovf[%0d]", mon_e.inst), mon_o, int'(mon_e.ovf));
      check($sformatf("tc[%0d]", mon_e.inst), mon_t, int'(mon_e.tc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit up_r;
    bit en_r;
    bit sc_r;
    bit ld_r;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1);
    #1 clr_n = 1'b0;
    #1 check_zero("reset");
    check("reset_tc1", int'(if1.tc), 0);

    cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    for (int k = 0; k < 520; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

    for (int k = 0; k < 25; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    cyc(1'b1, 1'b1, 1'b0, 1'b1, 8, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

    cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

    cyc(1'b1, 1'b0, 1'b0, 1'b1, 15, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    for (int k = 0; k < 37; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    reset_pulse();
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

    up_r = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) up_r = ~up_r;
      en_r = ($urandom_range(0, 3) != 0);
      sc_r = ($urandom_range(0, 59) == 0);
      ld_r = ($urandom_range(0, 29) == 0);
      cyc(1'b1, en_r, sc_r, ld_r, int'($urandom_range(0, 511)), up_r);
    end

    @(posedge clk);
    #3 check("queue_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
